// File: rtl/multdiv_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_sequencer_pkg
// Description : Shared constants and types for the multiply/divide sequencer.
//               Holds the opcode/alu_op decode values, the rstatus writeback
//               target with its exception codes, and the FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package multdiv_sequencer_pkg;

    // Instruction decode values
    localparam logic [4:0] OPCODE_RTYPE = 5'b00000;
    localparam logic [4:0] ALU_MUL      = 5'b00110;
    localparam logic [4:0] ALU_DIV      = 5'b00111;

    // Exception writeback target and codes (zero-extended to data width)
    localparam logic [4:0]  RSTATUS_REG = 5'd30;
    localparam logic [31:0] EXC_MUL     = 32'd4;
    localparam logic [31:0] EXC_DIV     = 32'd5;

    // Sequencer states; IDLE must stay at 00 so reset lands there
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_WAIT  = 2'b10,
        ST_WB    = 2'b11
    } md_state_e;

    // Kind of operation latched at issue
    typedef enum logic {
        MD_MUL = 1'b0,
        MD_DIV = 1'b1
    } md_kind_e;

endpackage
`default_nettype wire

// File: rtl/multdiv_sequencer_md_cycle_counter.sv
`default_nettype none
// ============================================================================
// Module      : md_cycle_counter
// Description : Wait-cycle counter for the multiply/divide sequencer.
//               Synchronous clear has priority over enable. terminal_o is
//               high while the count equals MAX_CYCLES-1.
// Ports       : clock, reset_n   - clock, async active-low reset
//               clear_i          - zero the count on the next edge
//               enable_i         - increment the count on the next edge
//               terminal_o       - count == MAX_CYCLES-1
// Revision    : 1.0 - initial release
// ============================================================================
module md_cycle_counter #(
    parameter int MAX_CYCLES = 40,
    parameter int CNT_W      = 6
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic terminal_o
);

    localparam logic [CNT_W-1:0] c_terminal = CNT_W'(MAX_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign terminal_o = (cnt_q == c_terminal);

endmodule
`default_nettype wire

// File: rtl/multdiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_sequencer
// Description : Multicycle sequencer between single-cycle decode and the
//               shared multiply/divide unit. Detects R-type mul/div, stalls
//               fetch, pulses the unit start, waits for ready with a bounded
//               timeout and performs exactly one register-file writeback:
//               the result to rd, or an exception code to rstatus ($r30).
// Ports       : clock, reset_n            - clock, async active-low reset
//               issue_valid, opcode,
//               alu_op, rd                - decoded instruction
//               md_ready, md_exception,
//               md_result                 - unit response (sampled in WAIT)
//               ctrl_mult, ctrl_div       - one-cycle start pulses
//               stall                     - hold fetch, suppress normal WB
//               wb_en, wb_addr, wb_data   - register-file write port
//               busy                      - sequencer not idle
// Revision    : 1.0 - initial release
// ============================================================================
module multdiv_sequencer
    import multdiv_sequencer_pkg::*;
#(
    parameter int MAX_CYCLES = 40,
    parameter int CNT_W      = 6
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        issue_valid,
    input  logic [4:0]  opcode,
    input  logic [4:0]  alu_op,
    input  logic [4:0]  rd,
    input  logic        md_ready,
    input  logic        md_exception,
    input  logic [31:0] md_result,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic        stall,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        busy
);

    md_state_e   state_q,  state_d;
    md_kind_e    kind_q,   kind_d;
    logic [4:0]  rd_q,     rd_d;
    logic [31:0] result_q, result_d;
    logic        exc_q,    exc_d;

    logic        md_issue;
    logic        is_mul;
    logic        is_div;
    logic        cnt_clr;
    logic        cnt_en;
    logic        cnt_terminal;

    assign is_mul   = (alu_op == ALU_MUL);
    assign is_div   = (alu_op == ALU_DIV);
    assign md_issue = issue_valid && (opcode == OPCODE_RTYPE) && (is_mul || is_div);

    md_cycle_counter #(
        .MAX_CYCLES (MAX_CYCLES),
        .CNT_W      (CNT_W)
    ) u_md_cycle_counter (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear_i    (cnt_clr),
        .enable_i   (cnt_en),
        .terminal_o (cnt_terminal)
    );

    // Next-state, latch updates and output decode
    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        rd_d      = rd_q;
        result_d  = result_q;
        exc_d     = exc_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
        stall     = 1'b0;
        wb_en     = 1'b0;
        wb_addr   = 5'd0;
        wb_data   = 32'd0;

        unique case (state_q)
            ST_IDLE: begin
                // The only path from an input to an output: fetch must be
                // held in the very cycle the mul/div is decoded.
                stall = md_issue;
                if (md_issue) begin
                    rd_d     = rd;
                    kind_d   = is_div ? MD_DIV : MD_MUL;
                    result_d = 32'd0;
                    exc_d    = 1'b0;
                    state_d  = ST_START;
                end
            end

            ST_START: begin
                stall     = 1'b1;
                ctrl_mult = (kind_q == MD_MUL);
                ctrl_div  = (kind_q == MD_DIV);
                cnt_clr   = 1'b1;
                state_d   = ST_WAIT;
            end

            ST_WAIT: begin
                stall  = 1'b1;
                cnt_en = 1'b1;
                // Ready takes priority over a coincident timeout.
                if (md_ready) begin
                    result_d = md_result;
                    exc_d    = md_exception;
                    state_d  = ST_WB;
                end else if (cnt_terminal) begin
                    exc_d    = 1'b1;
                    state_d  = ST_WB;
                end
            end

            ST_WB: begin
                if (exc_q) begin
                    wb_en   = 1'b1;
                    wb_addr = RSTATUS_REG;
                    wb_data = (kind_q == MD_DIV) ? EXC_DIV : EXC_MUL;
                end else if (rd_q != 5'd0) begin
                    wb_en   = 1'b1;
                    wb_addr = rd_q;
                    wb_data = result_q;
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy = (state_q != ST_IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            kind_q   <= MD_MUL;
            rd_q     <= 5'd0;
            result_q <= 32'd0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            rd_q     <= rd_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/multdiv_sequencer.md
# multdiv_sequencer

Multicycle sequencer between the single-cycle decode/control path and the shared multiply/divide unit. It detects R-type `mul`/`div`, freezes fetch while the unit runs, and issues a one-cycle start pulse. It waits for ready with a bounded timeout, then performs exactly one register-file writeback: the result to `rd`, or an exception code to `$r30` (rstatus).

## Interface
Parameters:
- `MAX_CYCLES`, 40: WAIT cycles allowed before timeout; must be ≥ 2.
- `CNT_W`, 6: counter width; must satisfy 2^CNT_W > MAX_CYCLES.

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `issue_valid`  in  1: decoded instruction is valid this cycle.
- `opcode`  in  5: instruction opcode.
- `alu_op`  in  5: R-type ALU op field.
- `rd`  in  5: destination register.
- `md_ready`  in  1: unit result valid; level, sampled in WAIT only.
- `md_exception`  in  1: unit error; sampled together with `md_ready`.
- `md_result`  in  32: unit result.
- `ctrl_mult`  out  1: one-cycle multiply start pulse.
- `ctrl_div`  out  1: one-cycle divide start pulse.
- `stall`  out  1: hold PC/fetch and suppress the normal writeback.
- `wb_en`  out  1: register-file write enable.
- `wb_addr`  out  5: write address.
- `wb_data`  out  32: write data.
- `busy`  out  1: state ≠ IDLE.

## Operation
- `md_issue` = `issue_valid` & `opcode`==00000 & (`alu_op`==00110 for MUL | `alu_op`==00111 for DIV).
- States: IDLE, START, WAIT, WB; 2-bit encoding, IDLE=00.
- IDLE:
  - On `md_issue`, latch `rd` and kind (mul/div) and go to START.
  - Otherwise stay in IDLE.
- START:
  - `ctrl_mult` or `ctrl_div` is high per latched kind; never both.
  - Clear the counter; go to WAIT.
  - `md_ready` is ignored.
- WAIT: the counter increments each cycle.
  - If `md_ready`: latch `md_result` and `md_exception`, go to WB.
  - Else if counter == MAX_CYCLES-1: force exception (timeout), go to WB.
- WB: go to IDLE next cycle.
  - No exception: `wb_en`=(latched rd ≠ 0), `wb_addr`=latched rd, `wb_data`=latched result.
  - Exception or timeout: `wb_en`=1, `wb_addr`=30, `wb_data`=4 for mul or 5 for div, zero-extended to 32 bits.
- `stall` = (IDLE & `md_issue`) | START | WAIT. This is the only combinational output path; all other outputs are registered or decoded from state.
- `issue_valid` is ignored outside IDLE; the upstream path is stalled by then.
- When `wb_en`=0, `wb_addr` and `wb_data` are 0.

## Timing
- Reset (async assert, sync release): state=IDLE, counter=0, latches=0. All outputs are 0 except `stall`, which follows `md_issue` combinationally.
- Issue at cycle N → START at N+1 → WAIT from N+2.
- `md_ready` first seen at cycle M ≥ N+2 → WB at M+1 → IDLE at M+2.
- Minimum occupancy: 4 cycles, including the issue cycle.
- `stall` is high from N through M; low in WB, so the PC advances at the WB edge.
- Timeout: WB at N+2+MAX_CYCLES.
- `md_ready` and timeout in the same cycle: ready wins; the result is used.
- `reset_n` asserted mid-operation: immediate return to IDLE. No start pulse and no writeback is emitted.
- Back-to-back: a new `md_issue` is accepted in the IDLE cycle after WB.

## Structure
- Shared package:
  - opcode constant R-type 00000; alu_op constants MUL 00110 and DIV 00111.
  - RSTATUS_REG=30; EXC_MUL=4, EXC_DIV=5.
  - State typedef/encoding.
- Natural sub-module: `md_cycle_counter`, with clear, enable and terminal-count (== MAX_CYCLES-1) output.
- Everything else is one FSM block.

## Test plan
- MUL to rd=5, `md_ready` and result 0x0000002A at START+3 → `ctrl_mult` single pulse at N+1. `stall` high N..N+4. WB at N+5 with `wb_en`=1, `wb_addr`=5, `wb_data`=0x2A.
- DIV with `md_ready` & `md_exception` in the first WAIT cycle → WB at N+3 with `wb_addr`=30, `wb_data`=5; `ctrl_mult` never asserts.
- MUL, `md_ready` never asserted, MAX_CYCLES=40 → WB at N+42 with `wb_addr`=30, `wb_data`=4; back to IDLE at N+43.
- MUL to rd=0, no exception → full sequence, `wb_en`=0 in WB. Then an immediate second DIV issue is accepted the next cycle.
- `reset_n` low during WAIT → all outputs 0 at once. After release, no `wb_en` and no start pulse until a new issue.
- Non-MD op (addi, opcode 00101) and R-type add with `issue_valid`=1 → `stall`=0, `busy`=0, no start pulses.
